// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus arbiter: FSM states,
// the default phase length, and the per-state bus drive pattern.
package rtc_bus_pkg;

  localparam int T_PHASE_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_SET   = 3'd1,
    A_STB   = 3'd2,
    A_HOLD  = 3'd3,
    D_SET   = 3'd4,
    D_STB   = 3'd5,
    D_HOLD  = 3'd6,
    RECOVER = 3'd7
  } state_t;

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic       ad_oe;
    logic [7:0] ad_out;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                a_d: 1'b0, ad_oe: 1'b0, ad_out: 8'h00};

  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      A_SET:   n = A_STB;
      A_STB:   n = A_HOLD;
      A_HOLD:  n = D_SET;
      D_SET:   n = D_STB;
      D_STB:   n = D_HOLD;
      D_HOLD:  n = RECOVER;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // Bus pattern for a given state; reads never drive the pad in the data phase.
  function automatic bus_t bus_drive(input state_t s, input logic is_wr,
                                     input logic [7:0] addr, input logic [7:0] data);
    bus_t b;
    b = BUS_IDLE;
    case (s)
      A_SET, A_STB, A_HOLD: begin
        b.cs_n   = 1'b0;
        b.ad_oe  = 1'b1;
        b.ad_out = addr;
        b.wr_n   = (s == A_STB) ? 1'b0 : 1'b1;
      end
      D_SET, D_STB, D_HOLD: begin
        b.cs_n = 1'b0;
        b.a_d  = 1'b1;
        if (is_wr) begin
          b.ad_oe  = 1'b1;
          b.ad_out = data;
          b.wr_n   = (s == D_STB) ? 1'b0 : 1'b1;
        end else begin
          b.rd_n = (s == D_STB) ? 1'b0 : 1'b1;
        end
      end
      default: b = BUS_IDLE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that times each bus phase; tc is high at count zero.
module rtc_phase_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       tc
);

  logic [7:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= 8'd0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != 8'd0) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  assign tc = (count_reg == 8'd0);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter between one read and one write requester, sequencing
// a multiplexed address/data RTC bus with fixed-length registered phases.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_done,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_done,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       a_d,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       busy
);

  localparam logic [7:0] PHASE_LOAD = 8'(T_PHASE - 1);

  state_t     state_reg, state_next;
  logic       op_wr_reg, op_wr_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] data_reg, data_next;
  logic       prefer_rd_reg;
  logic       grant, grant_wr, finish;
  logic       timer_load, phase_tc;
  bus_t       bus_reg;
  logic [7:0] rd_data_reg;
  logic       rd_done_reg, wr_done_reg, busy_reg;

  rtc_phase_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (PHASE_LOAD),
    .tc         (phase_tc)
  );

  // No grant in the done cycle, so a requester still holding its level
  // request while it sees done is not served twice.
  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    grant      = 1'b0;
    grant_wr   = 1'b0;
    finish     = 1'b0;
    if (state_reg == IDLE) begin
      if ((rd_req || wr_req) && !rd_done_reg && !wr_done_reg) begin
        grant      = 1'b1;
        grant_wr   = wr_req && (!rd_req || !prefer_rd_reg);
        state_next = A_SET;
        timer_load = 1'b1;
      end
    end else if (phase_tc) begin
      state_next = next_phase(state_reg);
      timer_load = (state_reg != RECOVER);
      finish     = (state_reg == RECOVER);
    end
  end

  assign op_wr_next = grant ? grant_wr : op_wr_reg;
  assign addr_next  = grant ? (grant_wr ? wr_addr : rd_addr) : addr_reg;
  assign data_next  = grant ? wr_data : data_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      op_wr_reg     <= 1'b0;
      addr_reg      <= 8'h00;
      data_reg      <= 8'h00;
      prefer_rd_reg <= 1'b0;
      bus_reg       <= BUS_IDLE;
      rd_data_reg   <= 8'h00;
      rd_done_reg   <= 1'b0;
      wr_done_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_wr_reg   <= op_wr_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      if (grant) begin
        prefer_rd_reg <= grant_wr;
      end
      bus_reg     <= bus_drive(state_next, op_wr_next, addr_next, data_next);
      rd_done_reg <= finish && !op_wr_reg;
      wr_done_reg <= finish && op_wr_reg;
      busy_reg    <= (state_next != IDLE);
      // Sample the pad on the last cycle of the read strobe.
      if (state_reg == D_STB && phase_tc && !op_wr_reg) begin
        rd_data_reg <= ad_in;
      end
    end
  end

  assign ad_out  = bus_reg.ad_out;
  assign ad_oe   = bus_reg.ad_oe;
  assign a_d     = bus_reg.a_d;
  assign cs_n    = bus_reg.cs_n;
  assign rd_n    = bus_reg.rd_n;
  assign wr_n    = bus_reg.wr_n;
  assign rd_data = rd_data_reg;
  assign rd_done = rd_done_reg;
  assign wr_done = wr_done_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench: directed write/read/arbitration/reset scenarios, then
// random traffic, all checked cycle by cycle against a phase-arithmetic model.
module tb_rtc_bus_arbiter;

  localparam int T = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       rd_req, wr_req;
  logic [7:0] rd_addr, wr_addr, wr_data, ad_in;
  logic [7:0] rd_data, ad_out;
  logic       rd_done, wr_done, ad_oe, a_d, cs_n, rd_n, wr_n, busy;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         viol     = 0;
  int         txn_no   = 0;
  bit         last_was_wr;
  logic [7:0] rd_data_m;

  always #5 clock = ~clock;

  rtc_bus_arbiter #(.T_PHASE(T)) dut (
    .clock   (clock),
    .reset   (reset),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_done (rd_done),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_done (wr_done),
    .ad_out  (ad_out),
    .ad_oe   (ad_oe),
    .ad_in   (ad_in),
    .a_d     (a_d),
    .cs_n    (cs_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .busy    (busy)
  );

  // Bus-safety watcher, active in every scenario.
  always @(negedge clock) begin
    if (!reset) begin
      if (ad_oe && !rd_n) viol++;
      if (!rd_n && !wr_n) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] obs();
    return {cs_n, rd_n, wr_n, a_d, ad_oe, busy, rd_done, wr_done};
  endfunction

  // ph 0..6 = the seven bus phases of a transaction, ph 7 = the done cycle.
  function automatic logic [7:0] exp_vec(input int ph, input bit wr);
    logic e_cs_n, e_rd_n, e_wr_n, e_a_d, e_oe, e_busy, e_rdd, e_wrd;
    e_cs_n = (ph >= 6);
    e_rd_n = !(ph == 4 && !wr);
    e_wr_n = !(ph == 1 || (ph == 4 && wr));
    e_a_d  = (ph >= 3 && ph <= 5);
    e_oe   = (ph <= 2) || (ph >= 3 && ph <= 5 && wr);
    e_busy = (ph <= 6);
    e_rdd  = (ph == 7 && !wr);
    e_wrd  = (ph == 7 && wr);
    return {e_cs_n, e_rd_n, e_wr_n, e_a_d, e_oe, e_busy, e_rdd, e_wrd};
  endfunction

  function automatic bit model_pick(input bit r, input bit w);
    if (r && w) return !last_was_wr;
    return w;
  endfunction

  task automatic check_reset_state();
    check("rst_vec", obs(), 8'hE0);
    check("rst_ad_out", ad_out, 8'h00);
    check("rst_rd_data", rd_data, 8'h00);
  endtask

  task automatic wait_grant(input int exp_n);
    int n;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!busy && n < 8);
    check("grant_busy", busy, 1'b1);
    check("grant_latency", n, exp_n);
  endtask

  // Called at the sample point of the first A_SET cycle after a grant.
  task automatic run_txn(input bit keep_req, input int reset_at, input bit scramble,
                         input bit drop_mid, input bit vary_pad, input logic [7:0] pad_val);
    bit         wr;
    logic [7:0] a, d;
    int         ph, w;
    wr = model_pick(rd_req, wr_req);
    a  = wr ? wr_addr : rd_addr;
    d  = wr_data;
    txn_no++;
    $display("txn %0d: %s addr=0x%02h data=0x%02h%s", txn_no, wr ? "WR" : "RD", a,
             wr ? d : pad_val, (reset_at > 0) ? " (reset mid-transaction)" : "");
    for (int c = 1; c <= 7 * T; c++) begin
      ph = (c - 1) / T;
      w  = (c - 1) % T;
      check($sformatf("bus_c%0d", c), obs(), exp_vec(ph, wr));
      if (ph <= 2) check("ad_out_addr", ad_out, a);
      else if (ph <= 5 && wr) check("ad_out_data", ad_out, d);
      if (c == reset_at) begin
        reset = 1'b1;
        ad_in = 8'h00;
        #1;
        check_reset_state();
        rd_data_m   = 8'h00;
        last_was_wr = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        check_reset_state();
        reset = 1'b0;
        return;
      end
      ad_in = (ph == 4 && !wr) ? ((vary_pad && w != T - 1) ? (pad_val ^ 8'h3C) : pad_val) : 8'h00;
      if (scramble && c == T + 2) begin
        if (wr) begin wr_data = 8'hFF; wr_addr = ~wr_addr; end
        else rd_addr = ~rd_addr;
      end
      if (drop_mid && c == 2 * T + 1) begin
        if (wr) wr_req = 1'b0; else rd_req = 1'b0;
      end
      @(posedge clock); #1;
    end
    ad_in = 8'h00;
    check("done_cycle", obs(), exp_vec(7, wr));
    if (!wr) rd_data_m = pad_val;
    check("rd_data", rd_data, rd_data_m);
    check("bus_excl", viol, 0);
    last_was_wr = wr;
    if (!keep_req) begin
      if (wr) wr_req = 1'b0; else rd_req = 1'b0;
    end
  endtask

  initial begin
    reset   = 1'b1;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    wr_addr = 8'h21;
    wr_data = 8'h59;
    rd_addr = 8'h22;
    ad_in   = 8'h00;
    last_was_wr = 1'b0;
    rd_data_m   = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state();
    reset = 1'b0;

    // Both requesters held from reset: W, R, W, R; wr_data toggled in the first write.
    wait_grant(1);
    run_txn(1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h45);
    wr_addr = 8'h21;
    wr_data = 8'h59;
    wait_grant(2);
    run_txn(1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h45);
    wait_grant(2);
    run_txn(1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h45);
    wait_grant(2);
    run_txn(1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h45);

    // Sole read, reset during D_STB, then restarted from A_SET.
    wr_req  = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 8'h33;
    wait_grant(2);
    run_txn(1'b0, 4 * T + 2, 1'b0, 1'b0, 1'b0, 8'h6E);
    wait_grant(1);
    run_txn(1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h9A);

    for (int i = 0; i < 16; i++) begin
      if (!rd_req && ($urandom % 2 == 0)) begin
        rd_req = 1'b1; rd_addr = 8'($urandom);
      end
      if (!wr_req && ($urandom % 2 == 0)) begin
        wr_req = 1'b1; wr_addr = 8'($urandom); wr_data = 8'($urandom);
      end
      if (!rd_req && !wr_req) begin
        if ($urandom % 2 == 0) begin rd_req = 1'b1; rd_addr = 8'($urandom); end
        else begin wr_req = 1'b1; wr_addr = 8'($urandom); wr_data = 8'($urandom); end
      end
      wait_grant(2);
      run_txn(1'b0, 0, 1'($urandom % 2), ($urandom % 4 == 0), 1'b1, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
